ikaopll_mix_accum: RTL and testbench

- Sits directly downstream of the OPLL core. Consumes the time-multiplexed o_MO/o_RO DAC samples and their sample strobes.
- Sums all melody and rhythm samples in one output frame, with rhythm weighted by RO_SHIFT, into a single signed PCM word.
- Hands completed words to the host audio path through a 2-entry valid/ready FIFO.
- Flags frames whose result was dropped because the FIFO was full.

---
 rtl/ikaopll_mix_accum.sv | 107 ++++++++++
 tb/tb_ikaopll_mix_accum.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_mix_accum.sv
// ikaopll_mix_accum: sums one frame of OPLL melody/rhythm samples into a saturated PCM word and queues it in a 2-entry FIFO.
//   i_EMUCLK/i_RST_n (async, active-low)/i_phiM_PCEN_n (active-low enable)
//   i_MO_SAMPLE/i_MO, i_RO_SAMPLE/i_RO : sample strobes and signed samples
//   i_FRAME_SYNC : frame boundary; i_CLR_FLAGS : clears sticky flags
//   o_PCM/o_PCM_VALID/i_PCM_READY : FIFO head handshake
//   o_MO_CNT/o_RO_CNT : strobe counts of last closed frame; o_OVERRUN/o_CLIP : sticky flags
module ikaopll_mix_accum #(
  parameter int RO_SHIFT   = 1,
  parameter int OUT_SHIFT  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST_n,
  input  logic        i_phiM_PCEN_n,
  input  logic        i_MO_SAMPLE,
  input  logic        i_RO_SAMPLE,
  input  logic [9:0]  i_MO,
  input  logic [9:0]  i_RO,
  input  logic        i_FRAME_SYNC,
  input  logic        i_CLR_FLAGS,
  output logic [15:0] o_PCM,
  output logic        o_PCM_VALID,
  input  logic        i_PCM_READY,
  output logic [4:0]  o_MO_CNT,
  output logic [4:0]  o_RO_CNT,
  output logic        o_OVERRUN,
  output logic        o_CLIP
);
  typedef enum logic {WAIT_SYNC, ACCUM} state_t;
  state_t state, state_nxt;
  logic en, mo_d, ro_d, sync_d, mo_ev, ro_ev, sync_ev, close, acc_upd;
  logic signed [17:0] acc, acc_nxt;
  logic signed [19:0] add_mo, add_ro, sum;
  logic signed [21:0] scaled;
  logic [15:0] result, head, tail, head_nxt, tail_nxt;
  logic clip_det, full, pop, push, drop, overrun, clip;
  logic [1:0] cnt, cnt_nxt;
  logic [4:0] mo_cnt, ro_cnt, mo_base, ro_base, mo_cnt_nxt, ro_cnt_nxt, mo_last, ro_last;
  assign en      = ~i_phiM_PCEN_n;
  assign mo_ev   = en & i_MO_SAMPLE & ~mo_d;
  assign ro_ev   = en & i_RO_SAMPLE & ~ro_d;
  assign sync_ev = en & i_FRAME_SYNC & ~sync_d;
  assign close   = sync_ev & (state == ACCUM);
  assign full    = cnt == 2'(FIFO_DEPTH);
  assign pop     = en & (cnt != 2'd0) & i_PCM_READY;
  assign push    = close & (~full | pop);
  assign drop    = close & full & ~pop;
  always_comb begin
    state_nxt  = sync_ev ? ACCUM : state;
    acc_upd    = (state == ACCUM) | sync_ev;
    add_mo     = mo_ev ? 20'($signed(i_MO)) : '0;
    add_ro     = ro_ev ? 20'($signed(i_RO)) <<< RO_SHIFT : '0;
    // a strobe coinciding with sync seeds the new frame instead of the old one
    sum        = (sync_ev ? 20'sd0 : 20'(acc)) + add_mo + add_ro;
    acc_nxt    = sum > 20'sd131071 ? 18'sd131071 : sum < -20'sd131071 ? -18'sd131071 : sum[17:0];
    mo_base    = sync_ev ? 5'd0 : mo_cnt;
    ro_base    = sync_ev ? 5'd0 : ro_cnt;
    mo_cnt_nxt = mo_ev && mo_base != 5'd31 ? mo_base + 5'd1 : mo_base;
    ro_cnt_nxt = ro_ev && ro_base != 5'd31 ? ro_base + 5'd1 : ro_base;
    scaled     = 22'(acc) <<< OUT_SHIFT;
    clip_det   = scaled > 22'sd32767 || scaled < -22'sd32768;
    result     = scaled > 22'sd32767 ? 16'h7fff : scaled < -22'sd32768 ? 16'h8000 : scaled[15:0];
    // head refills from tail when two are queued; an empty FIFO keeps its last word
    head_nxt   = pop && cnt == 2'd2 ? tail : push && (cnt == 2'd0 || (pop && cnt == 2'd1)) ? result : head;
    tail_nxt   = push && ((cnt == 2'd1 && !pop) || cnt == 2'd2) ? result : tail;
    cnt_nxt    = cnt + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state   <= WAIT_SYNC;
      {mo_d, ro_d, sync_d} <= '0;
      acc     <= '0;
      mo_cnt  <= '0;
      ro_cnt  <= '0;
      mo_last <= '0;
      ro_last <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
      clip    <= 1'b0;
    end else if (en) begin
      state   <= state_nxt;
      {mo_d, ro_d, sync_d} <= {i_MO_SAMPLE, i_RO_SAMPLE, i_FRAME_SYNC};
      if (acc_upd) begin
        acc    <= acc_nxt;
        mo_cnt <= mo_cnt_nxt;
        ro_cnt <= ro_cnt_nxt;
      end
      if (close) begin
        mo_last <= mo_cnt;
        ro_last <= ro_cnt;
      end
      head    <= head_nxt;
      tail    <= tail_nxt;
      cnt     <= cnt_nxt;
      overrun <= drop | (overrun & ~i_CLR_FLAGS);
      clip    <= (close & clip_det) | (clip & ~i_CLR_FLAGS);
    end
  end
  assign o_PCM       = head;
  assign o_PCM_VALID = cnt != 2'd0;
  assign o_MO_CNT    = mo_last;
  assign o_RO_CNT    = ro_last;
  assign o_OVERRUN   = overrun;
  assign o_CLIP      = clip;
endmodule

// File: tb/tb_ikaopll_mix_accum.sv
// tb_ikaopll_mix_accum: directed self-checking bench for ikaopll_mix_accum.
module tb_ikaopll_mix_accum;
  logic clk = 0, rst_n = 0, pcen_n = 1, mo_s = 0, ro_s = 0, fs = 0, clr = 0, rdy = 0;
  logic [9:0] mo = 0, ro = 0;
  logic [15:0] pcm;
  logic valid, overrun, clip;
  logic [4:0] mo_cnt, ro_cnt;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ikaopll_mix_accum dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n),
    .i_MO_SAMPLE(mo_s), .i_RO_SAMPLE(ro_s), .i_MO(mo), .i_RO(ro),
    .i_FRAME_SYNC(fs), .i_CLR_FLAGS(clr),
    .o_PCM(pcm), .o_PCM_VALID(valid), .i_PCM_READY(rdy),
    .o_MO_CNT(mo_cnt), .o_RO_CNT(ro_cnt), .o_OVERRUN(overrun), .o_CLIP(clip)
  );
  task automatic en_edge();
    pcen_n = 0;
    @(posedge clk);
    #1 pcen_n = 1;
  endtask
  task automatic dis_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic mo_pulse(input logic [9:0] v);
    mo = v; mo_s = 1; en_edge(); mo_s = 0; en_edge();
  endtask
  task automatic ro_pulse(input logic [9:0] v);
    ro = v; ro_s = 1; en_edge(); ro_s = 0; en_edge();
  endtask
  task automatic sync();
    fs = 1; en_edge(); fs = 0; en_edge();
  endtask
  task automatic pop_one();
    rdy = 1; en_edge(); rdy = 0;
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask
  task automatic test_reset();
    rst_n = 0; #12 rst_n = 1; dis_edge();
    n_chk++;
    if ({pcm, valid, mo_cnt, ro_cnt, overrun, clip} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pcm=%0d valid=%b mo=%0d ro=%0d ovr=%b clip=%b expected all 0", pcm, valid, mo_cnt, ro_cnt, overrun, clip);
    end
  endtask
  task automatic test_basic();
    sync();
    for (int i = 0; i < 9; i++) mo_pulse(10'd100);
    for (int i = 0; i < 6; i++) ro_pulse(-10'sd50);
    fs = 1; en_edge(); fs = 0;
    n_chk++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %b expected 1", valid); end
    n_chk++;
    if (pcm !== 16'd1200) begin n_fail++; $display("FAIL basic_pcm: got %0d expected 1200", $signed(pcm)); end
    n_chk++;
    if (mo_cnt !== 5'd9) begin n_fail++; $display("FAIL basic_mo_cnt: got %0d expected 9", mo_cnt); end
    n_chk++;
    if (ro_cnt !== 5'd6) begin n_fail++; $display("FAIL basic_ro_cnt: got %0d expected 6", ro_cnt); end
    pop_one();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_empty: got valid %b expected 0", valid); end
    n_chk++;
    if (pcm !== 16'd1200) begin n_fail++; $display("FAIL basic_pcm_hold: got %0d expected 1200", $signed(pcm)); end
  endtask
  task automatic test_presync_discard();
    rst_n = 0; #3 rst_n = 1;
    for (int i = 0; i < 3; i++) mo_pulse(10'd100);
    sync();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL presync_no_push: got valid %b expected 0", valid); end
    sync();
    n_chk++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL presync_valid: got %b expected 1", valid); end
    chk("presync_pcm", pcm, 16'd0);
    chk("presync_mo_cnt", 16'(mo_cnt), 16'd0);
    pop_one();
  endtask
  task automatic test_enable();
    mo = 10'd50; mo_s = 1;
    for (int i = 0; i < 3; i++) dis_edge();
    mo_s = 0;
    sync();
    chk("enable_gated_pcm", pcm, 16'd0);
    chk("enable_gated_cnt", 16'(mo_cnt), 16'd0);
    rdy = 1; dis_edge(); rdy = 0;
    n_chk++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL enable_ready_ignored: got valid %b expected 1", valid); end
    pop_one();
  endtask
  task automatic test_clip();
    for (int i = 0; i < 16; i++) mo_pulse(10'd511);
    for (int i = 0; i < 2; i++) ro_pulse(10'd511);
    sync();
    chk("clip_pcm", pcm, 16'd32767);
    chk("clip_flag", 16'(clip), 16'd1);
    chk("clip_mo_cnt", 16'(mo_cnt), 16'd16);
    clr = 1; en_edge(); clr = 0;
    chk("clip_cleared", 16'(clip), 16'd0);
    pop_one();
    for (int i = 0; i < 16; i++) mo_pulse(-10'sd512);
    sync();
    chk("clip_neg_pcm", pcm, 16'h8000);
    clr = 1; pop_one(); clr = 0;
  endtask
  task automatic test_overrun();
    mo_pulse(10'd1); sync();
    mo_pulse(10'd2); sync();
    mo_pulse(10'd3); sync();
    chk("ovr_flag", 16'(overrun), 16'd1);
    chk("ovr_head0", pcm, 16'd4);
    pop_one();
    chk("ovr_head1", pcm, 16'd8);
    pop_one();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_third_dropped: got valid %b expected 0", valid); end
    clr = 1; en_edge(); clr = 0;
    chk("ovr_cleared", 16'(overrun), 16'd0);
    mo_pulse(10'd1); sync();
    mo_pulse(10'd2); sync();
    mo_pulse(10'd3);
    fs = 1; rdy = 1; en_edge(); fs = 0; rdy = 0; en_edge();
    chk("ovr_pushpop_flag", 16'(overrun), 16'd0);
    chk("ovr_pushpop_head", pcm, 16'd8);
    pop_one();
    chk("ovr_pushpop_tail", pcm, 16'd12);
    pop_one();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got valid %b expected 0", valid); end
  endtask
  task automatic test_back_to_back();
    mo_pulse(10'd5);
    mo = 10'd7; mo_s = 1; fs = 1; en_edge(); mo_s = 0; fs = 0; en_edge();
    chk("coedge_closed_pcm", pcm, 16'd20);
    chk("coedge_closed_cnt", 16'(mo_cnt), 16'd1);
    pop_one();
    sync();
    chk("coedge_next_pcm", pcm, 16'd28);
    chk("coedge_next_cnt", 16'(mo_cnt), 16'd1);
    pop_one();
    mo = 10'd10; mo_s = 1;
    for (int i = 0; i < 5; i++) en_edge();
    mo_s = 0;
    sync();
    chk("held_pcm", pcm, 16'd40);
    chk("held_cnt", 16'(mo_cnt), 16'd1);
    pop_one();
  endtask
  task automatic test_async_reset();
    mo_pulse(10'd3); sync();
    mo_pulse(10'd3);
    chk("pre_reset_pcm", pcm, 16'd12);
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({pcm, valid, mo_cnt, ro_cnt, overrun, clip} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got pcm=%0d valid=%b mo=%0d ro=%0d expected all 0", pcm, valid, mo_cnt, ro_cnt);
    end
    #3 rst_n = 1;
    dis_edge();
    mo_pulse(10'd100); sync();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_wait: got valid %b expected 0", valid); end
    mo_pulse(10'd1); sync();
    chk("post_reset_pcm", pcm, 16'd4);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_presync_discard();
    test_enable();
    test_clip();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
